// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 datapath register bank.
package mips_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ZERO_REG = 0;

   // Address width for a bank of n registers (at least one bit).
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/reg_file_bank_if.sv
// Register bank port bundle: one strobed write port, two read ports.
interface reg_file_bank_if
   import mips_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int ADDR_W = addr_w(NUM_REGS)
);
   logic              we;
   logic              strobe;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [WIDTH-1:0]  rdata1;
   logic [WIDTH-1:0]  rdata2;
   logic              wr_ack;

   modport master (
      output we, strobe, waddr, wdata, raddr1, raddr2,
      input  rdata1, rdata2, wr_ack
   );

   modport slave (
      input  we, strobe, waddr, wdata, raddr1, raddr2,
      output rdata1, rdata2, wr_ack
   );
endinterface

// File: rtl/reg_cell.sv
// Single WIDTH-bit register, async active-high clear, loads on ld & strobe.
module reg_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic             strobe,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // Hold value unless qualified load; clear dominates asynchronously.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)               q <= '0;
      else if (ld && strobe) q <= d;
   end
endmodule

// File: rtl/reg_file_bank.sv
// NREGS x WIDTH register bank, register 0 reads as zero.
// Optional feature macro: REG_FILE_BYPASS_EN forwards same-cycle write data
// to a read port addressing the register being written.
module reg_file_bank
   import mips_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int NREGS  = NUM_REGS,
   parameter int ADDR_W = addr_w(NREGS)
) (
   input  logic          clk,
   input  logic          clr,
   reg_file_bank_if.slave bus
);
   // Decode space is rounded up to a power of two; slots past NREGS and
   // slot 0 are tied to zero so a read mux index never needs a range check.
   localparam int NSLOT = 1 << ADDR_W;

   logic [NSLOT-1:0][WIDTH-1:0] q;
   logic                        in_range;
   logic                        wr_hit;
   logic                        wr_ack_q;

   assign in_range = ({1'b0, bus.waddr} < (ADDR_W+1)'(NREGS));
   assign wr_hit   = bus.we & bus.strobe & ~clr & in_range &
                     (bus.waddr != ADDR_W'(ZERO_REG));

   generate
      for (genvar i = 0; i < NSLOT; i++) begin : g_slot
         if (i == ZERO_REG || i >= NREGS) begin : g_zero
            assign q[i] = '0;
         end else begin : g_cell
            reg_cell #(.WIDTH(WIDTH)) u_cell (
               .clk    (clk),
               .clr    (clr),
               .ld     (bus.we & (bus.waddr == ADDR_W'(i))),
               .strobe (bus.strobe),
               .d      (bus.wdata),
               .q      (q[i])
            );
         end
      end
   endgenerate

   // Write acknowledge: one-cycle pulse after a committed write.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) wr_ack_q <= 1'b0;
      else     wr_ack_q <= wr_hit;
   end

   assign bus.wr_ack = wr_ack_q;

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      bus.rdata1 = q[bus.raddr1];
      bus.rdata2 = q[bus.raddr2];
`ifdef REG_FILE_BYPASS_EN
      // wr_hit already excludes register 0, out-of-range and clr.
      if (wr_hit && (bus.raddr1 == bus.waddr)) bus.rdata1 = bus.wdata;
      if (wr_hit && (bus.raddr2 == bus.waddr)) bus.rdata2 = bus.wdata;
`else
`endif
   end
endmodule
